// File: rtl/ps2_key_tracker_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ps2_key_tracker_if
// Description : Bundles the raw PS/2 pins with the decoded key flags and the
//               receive status pulses of ps2_key_tracker. The master side is
//               the tracker, which reads the pins and drives the key outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_key_tracker_if;
  // Raw PS/2 pins, asynchronous to Clk, idle high
  logic       ps2_clk;
  logic       ps2_data;

  // Fireboy keys
  logic       w_key;
  logic       a_key;
  logic       d_key;

  // Watergirl keys
  logic       up_key;
  logic       left_key;
  logic       right_key;

  logic       enter_key;

  // Receiver status
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output w_key, a_key, d_key,
    output up_key, left_key, right_key,
    output enter_key,
    output code, code_valid, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  w_key, a_key, d_key,
    input  up_key, left_key, right_key,
    input  enter_key,
    input  code, code_valid, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ps2_key_tracker
// Description : PS/2 keyboard receiver (scan code set 2). Synchronizes the
//               pins, deframes 11-bit frames with parity/stop/timeout checks
//               and keeps one held/released flag per game key.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               Clk,
  input  logic               Reset,
  ps2_key_tracker_if.master  bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        c_STOP_BIT = 4'd9;

  localparam logic [7:0] c_CODE_EXT      = 8'hE0;
  localparam logic [7:0] c_CODE_BRK      = 8'hF0;
  localparam logic [7:0] c_CODE_PAUSE    = 8'hE1;
  localparam logic [7:0] c_CODE_SELFTEST = 8'hAA;

  localparam logic [7:0] c_CODE_W     = 8'h1D;
  localparam logic [7:0] c_CODE_A     = 8'h1C;
  localparam logic [7:0] c_CODE_D     = 8'h23;
  localparam logic [7:0] c_CODE_ENTER = 8'h5A;
  localparam logic [7:0] c_CODE_UP    = 8'h75;
  localparam logic [7:0] c_CODE_LEFT  = 8'h6B;
  localparam logic [7:0] c_CODE_RIGHT = 8'h74;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic               r_clk_s1;
  logic               r_clk_s2;
  logic               r_clk_prev;
  logic               r_dat_s1;
  logic               r_dat_s2;
  logic               w_fall;
  logic               w_bit;

  state_t             r_state;
  logic [3:0]         r_bit_cnt;
  logic [8:0]         r_shift;
  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic [7:0]         r_code;
  logic               r_code_valid;
  logic               r_frame_err;

  logic               r_ext;
  logic               r_brk;
  logic               r_w_key;
  logic               r_a_key;
  logic               r_d_key;
  logic               r_up_key;
  logic               r_left_key;
  logic               r_right_key;
  logic               r_enter_key;

  // --------------------------------------------------------------------------
  // Synchronizer: two flops per pin plus an edge-detect flop on the clock.
  // Everything resets to the idle-high level so no edge is seen after reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= bus.ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= bus.ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  // Data travels through the same depth as the clock, so it is sampled
  // with the same alignment the keyboard gave it on the pins.
  assign w_fall = r_clk_prev & ~r_clk_s2;
  assign w_bit  = r_dat_s2;

  // --------------------------------------------------------------------------
  // Frame receiver: start bit, 8 data bits LSB first, odd parity, stop.
  // A mid-frame stall longer than TIMEOUT_CYCLES aborts with an error.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 9'd0;
      r_tmo_cnt    <= '0;
      r_code       <= 8'h00;
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tmo_cnt <= '0;
          r_bit_cnt <= 4'd0;
          // A high "start bit" is line noise and is simply ignored
          if (w_fall && !w_bit) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // An edge in the same cycle as the timeout takes priority
          if (w_fall) begin
            r_tmo_cnt <= '0;
            if (r_bit_cnt == c_STOP_BIT) begin
              // Data + parity must hold an odd count of ones, stop must be 1
              if ((^r_shift) && w_bit) begin
                r_code       <= r_shift[7:0];
                r_code_valid <= 1'b1;
              end else begin
                r_frame_err  <= 1'b1;
              end
              r_state   <= ST_IDLE;
              r_bit_cnt <= 4'd0;
            end else begin
              // Shift in from the top so data bit 0 ends up in r_shift[0]
              r_shift   <= {w_bit, r_shift[8:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else if (r_tmo_cnt == c_TMO_LAST) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
            r_tmo_cnt   <= '0;
            r_bit_cnt   <= 4'd0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Scan decoder: tracks E0/F0 prefixes and updates the mapped key flags.
  // The extended prefix is part of the match, so keypad and arrow codes
  // sharing a byte value stay distinct.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_w_key     <= 1'b0;
      r_a_key     <= 1'b0;
      r_d_key     <= 1'b0;
      r_up_key    <= 1'b0;
      r_left_key  <= 1'b0;
      r_right_key <= 1'b0;
      r_enter_key <= 1'b0;
    end else if (r_frame_err) begin
      // A corrupted byte may have been part of a prefixed sequence
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_code_valid) begin
      if (r_code == c_CODE_EXT) begin
        r_ext <= 1'b1;
      end else if (r_code == c_CODE_BRK) begin
        r_brk <= 1'b1;
      end else if (r_code == c_CODE_PAUSE) begin
        r_ext <= r_ext;
      end else if ((r_code == c_CODE_SELFTEST) && !r_ext) begin
        // Keyboard power-on self-test passed: nothing can be held
        r_ext       <= 1'b0;
        r_brk       <= 1'b0;
        r_w_key     <= 1'b0;
        r_a_key     <= 1'b0;
        r_d_key     <= 1'b0;
        r_up_key    <= 1'b0;
        r_left_key  <= 1'b0;
        r_right_key <= 1'b0;
        r_enter_key <= 1'b0;
      end else begin
        if (r_ext) begin
          case (r_code)
            c_CODE_UP:    r_up_key    <= ~r_brk;
            c_CODE_LEFT:  r_left_key  <= ~r_brk;
            c_CODE_RIGHT: r_right_key <= ~r_brk;
            default:      ;
          endcase
        end else begin
          case (r_code)
            c_CODE_W:     r_w_key     <= ~r_brk;
            c_CODE_A:     r_a_key     <= ~r_brk;
            c_CODE_D:     r_d_key     <= ~r_brk;
            c_CODE_ENTER: r_enter_key <= ~r_brk;
            default:      ;
          endcase
        end
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all straight from registers
  // --------------------------------------------------------------------------
  assign bus.w_key      = r_w_key;
  assign bus.a_key      = r_a_key;
  assign bus.d_key      = r_d_key;
  assign bus.up_key     = r_up_key;
  assign bus.left_key   = r_left_key;
  assign bus.right_key  = r_right_key;
  assign bus.enter_key  = r_enter_key;
  assign bus.code       = r_code;
  assign bus.code_valid = r_code_valid;
  assign bus.frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ps2_key_tracker
// Description : Self-checking bench for ps2_key_tracker. Drives PS/2 frames
//               bit by bit and compares against a table-driven key model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_tracker;

  localparam int TMO = 200;   // timeout used by the DUT instance
  localparam int H   = 20;    // PS/2 half period in Clk cycles

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  ps2_key_tracker_if bus();

  ps2_key_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Key vector order: {right, left, up, enter, d, a, w}
  wire [6:0] w_keys = {bus.right_key, bus.left_key, bus.up_key, bus.enter_key,
                       bus.d_key, bus.a_key, bus.w_key};

  // --------------------------------------------------------------------------
  // Cycle counter and output monitor
  // --------------------------------------------------------------------------
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int         cv_count = 0, fe_count = 0, both_cnt = 0;
  int         cv_cycle = 0, fe_cycle = 0, fall_cycle = 0;
  logic [7:0] last_code = 8'h00;
  logic [6:0] keys_at_cv = '0, keys_after_cv = '0;
  bit         pend = 0;

  always @(negedge Clk) begin
    if (pend) begin
      keys_after_cv = w_keys;
      pend = 0;
    end
    if (bus.code_valid === 1'b1) begin
      cv_count++;
      cv_cycle   = cyc;
      last_code  = bus.code;
      keys_at_cv = w_keys;
      pend = 1;
    end
    if (bus.frame_err === 1'b1) begin
      fe_count++;
      fe_cycle = cyc;
    end
    if (bus.code_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
  end

  // --------------------------------------------------------------------------
  // Reference model: a lookup table of (extended, byte) -> key slot
  // --------------------------------------------------------------------------
  logic [7:0] map_code [7] = '{8'h1D, 8'h1C, 8'h23, 8'h5A, 8'h75, 8'h6B, 8'h74};
  bit         map_ext  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [6:0] m_keys = '0;
  bit         m_ext  = 0;
  bit         m_brk  = 0;

  function automatic void model_reset();
    m_keys = '0; m_ext = 0; m_brk = 0;
  endfunction

  function automatic void model_err();
    m_ext = 0; m_brk = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) ;
    else if (b == 8'hAA && !m_ext) model_reset();
    else begin
      for (int i = 0; i < 7; i++)
        if (map_code[i] == b && map_ext[i] == m_ext) m_keys[i] = !m_brk;
      m_ext = 0; m_brk = 0;
    end
  endfunction

  // --------------------------------------------------------------------------
  // PS/2 line drivers
  // --------------------------------------------------------------------------
  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (H) @(negedge Clk);
    bus.ps2_clk = 1'b0;
    fall_cycle  = cyc;
    repeat (H) @(negedge Clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                      output int dcv, output int dfe);
    int cv0 = cv_count;
    int fe0 = fe_count;
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    bus.ps2_data = 1'b1;
    repeat (8) @(negedge Clk);
    dcv = cv_count - cv0;
    dfe = fe_count - fe0;
    if (!bad_par && !bad_stop) model_byte(b);
    else model_err();
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1; Reset = 1'b1;
    repeat (4) @(negedge Clk);
    checks++; if (w_keys !== 7'd0) begin errors++; $display("FAIL reset_keys got=%b exp=0", w_keys); end
    checks++; if (bus.code !== 8'h00) begin errors++; $display("FAIL reset_code got=%h exp=00", bus.code); end
    checks++; if (bus.code_valid !== 1'b0) begin errors++; $display("FAIL reset_cv got=%b exp=0", bus.code_valid); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got=%b exp=0", bus.frame_err); end
    Reset = 1'b0;
    model_reset();
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_make_break();
    int dcv, dfe;
    xfer(8'h1D, 0, 0, dcv, dfe);
    checks++; if (dcv !== 1 || dfe !== 0) begin errors++; $display("FAIL mk_pulses cv=%0d fe=%0d exp 1/0", dcv, dfe); end
    checks++; if (last_code !== 8'h1D) begin errors++; $display("FAIL mk_code got=%h exp=1d", last_code); end
    checks++; if (cv_cycle - fall_cycle !== 3) begin errors++; $display("FAIL mk_latency got=%0d exp=3", cv_cycle - fall_cycle); end
    checks++; if (keys_at_cv !== 7'd0) begin errors++; $display("FAIL mk_key_early got=%b exp=0", keys_at_cv); end
    checks++; if (keys_after_cv !== m_keys) begin errors++; $display("FAIL mk_key_next got=%b exp=%b", keys_after_cv, m_keys); end
    checks++; if (w_keys !== 7'b0000001) begin errors++; $display("FAIL mk_w_only got=%b exp=0000001", w_keys); end
    xfer(8'hF0, 0, 0, dcv, dfe);
    checks++; if (w_keys !== m_keys) begin errors++; $display("FAIL brk_prefix got=%b exp=%b", w_keys, m_keys); end
    xfer(8'h1D, 0, 0, dcv, dfe);
    checks++; if (dcv !== 1) begin errors++; $display("FAIL brk_pulse got=%0d exp=1", dcv); end
    checks++; if (w_keys !== 7'd0) begin errors++; $display("FAIL brk_keys got=%b exp=0", w_keys); end
  endtask

  task automatic test_extended();
    int dcv, dfe;
    xfer(8'hE0, 0, 0, dcv, dfe);
    xfer(8'h75, 0, 0, dcv, dfe);
    checks++; if (w_keys !== m_keys || bus.up_key !== 1'b1) begin errors++; $display("FAIL ext_up_make got=%b exp=%b", w_keys, m_keys); end
    xfer(8'h75, 0, 0, dcv, dfe);
    checks++; if (bus.up_key !== 1'b1) begin errors++; $display("FAIL ext_keypad8 got=%b exp=1", bus.up_key); end
    xfer(8'hE0, 0, 0, dcv, dfe);
    xfer(8'hF0, 0, 0, dcv, dfe);
    xfer(8'h75, 0, 0, dcv, dfe);
    checks++; if (w_keys !== m_keys || bus.up_key !== 1'b0) begin errors++; $display("FAIL ext_up_break got=%b exp=%b", w_keys, m_keys); end
    // A plain make of 1D only lands on w_key if both prefixes were cleared
    xfer(8'h1D, 0, 0, dcv, dfe);
    checks++; if (bus.w_key !== 1'b1) begin errors++; $display("FAIL ext_flags_clear got=%b exp=1", bus.w_key); end
    xfer(8'hE0, 0, 0, dcv, dfe);
    xfer(8'h1D, 0, 0, dcv, dfe);
    checks++; if (bus.w_key !== 1'b1 || w_keys !== m_keys) begin errors++; $display("FAIL ext_e0_1d got=%b exp=%b", w_keys, m_keys); end
  endtask

  task automatic test_frame_errors();
    int dcv, dfe;
    xfer(8'h1C, 1, 0, dcv, dfe);
    checks++; if (dfe !== 1 || dcv !== 0) begin errors++; $display("FAIL par_err cv=%0d fe=%0d exp 0/1", dcv, dfe); end
    checks++; if (bus.a_key !== 1'b0) begin errors++; $display("FAIL par_akey got=%b exp=0", bus.a_key); end
    xfer(8'h1C, 0, 0, dcv, dfe);
    checks++; if (bus.a_key !== 1'b1 || w_keys !== m_keys) begin errors++; $display("FAIL par_recover got=%b exp=%b", w_keys, m_keys); end
    xfer(8'h23, 0, 1, dcv, dfe);
    checks++; if (dfe !== 1 || dcv !== 0 || w_keys !== m_keys) begin errors++; $display("FAIL stop_err cv=%0d fe=%0d keys=%b exp=%b", dcv, dfe, w_keys, m_keys); end
    // Error after E0 must drop the prefix: the next 75 is keypad 8
    xfer(8'hE0, 0, 0, dcv, dfe);
    xfer(8'h6B, 1, 0, dcv, dfe);
    xfer(8'h75, 0, 0, dcv, dfe);
    checks++; if (w_keys !== m_keys) begin errors++; $display("FAIL err_clears_ext got=%b exp=%b", w_keys, m_keys); end
  endtask

  task automatic test_timeout();
    int dcv, dfe, fe0, c;
    fe0 = fe_count;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
    c = fall_cycle;
    bus.ps2_data = 1'b1;
    repeat (TMO + 20) @(negedge Clk);
    model_err();
    checks++; if (fe_count - fe0 !== 1) begin errors++; $display("FAIL tmo_pulse got=%0d exp=1", fe_count - fe0); end
    checks++; if (fe_cycle < c + TMO || fe_cycle > c + TMO + 6) begin errors++; $display("FAIL tmo_time got=%0d exp=%0d..%0d", fe_cycle, c + TMO, c + TMO + 6); end
    xfer(8'h23, 0, 0, dcv, dfe);
    checks++; if (bus.d_key !== 1'b1 || dcv !== 1 || w_keys !== m_keys) begin errors++; $display("FAIL tmo_recover got=%b exp=%b", w_keys, m_keys); end
  endtask

  task automatic test_selftest();
    int dcv, dfe;
    xfer(8'h1D, 0, 0, dcv, dfe);
    xfer(8'h23, 0, 0, dcv, dfe);
    xfer(8'hE0, 0, 0, dcv, dfe);
    xfer(8'h6B, 0, 0, dcv, dfe);
    checks++; if (w_keys !== m_keys || bus.left_key !== 1'b1) begin errors++; $display("FAIL st_held got=%b exp=%b", w_keys, m_keys); end
    xfer(8'hAA, 0, 0, dcv, dfe);
    checks++; if (w_keys !== 7'd0) begin errors++; $display("FAIL st_clear got=%b exp=0", w_keys); end
  endtask

  task automatic test_reset_midframe();
    int dcv, dfe, fe0;
    fe0 = fe_count;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    checks++; if (w_keys !== 7'd0 || bus.code !== 8'h00 || bus.code_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid keys=%b code=%h cv=%b fe=%b exp 0", w_keys, bus.code, bus.code_valid, bus.frame_err); end
    Reset = 1'b0;
    model_reset();
    repeat (TMO + 10) @(negedge Clk);
    checks++; if (fe_count !== fe0) begin errors++; $display("FAIL rst_no_err got=%0d exp=0", fe_count - fe0); end
    xfer(8'h5A, 0, 0, dcv, dfe);
    checks++; if (dcv !== 1 || last_code !== 8'h5A || bus.enter_key !== 1'b1) begin
      errors++; $display("FAIL rst_recover cv=%0d code=%h enter=%b exp 1/5a/1", dcv, last_code, bus.enter_key); end
  endtask

  task automatic test_random();
    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h23, 8'h5A,
                              8'h75, 8'h6B, 8'h74, 8'h12, 8'hE1, 8'hAA};
    int dcv, dfe;
    logic [7:0] b;
    bit bad;
    for (int n = 0; n < 40; n++) begin
      b   = pool[$urandom_range(0, 11)];
      bad = ($urandom_range(0, 7) == 0);
      xfer(b, bad, 0, dcv, dfe);
      checks++; if (dcv !== (bad ? 0 : 1) || dfe !== (bad ? 1 : 0)) begin
        errors++; $display("FAIL rnd_pulse n=%0d cv=%0d fe=%0d bad=%0d", n, dcv, dfe, bad); end
      checks++; if (w_keys !== m_keys) begin errors++; $display("FAIL rnd_keys n=%0d byte=%h got=%b exp=%b", n, b, w_keys, m_keys); end
      if (!bad) begin
        checks++; if (last_code !== b) begin errors++; $display("FAIL rnd_code n=%0d got=%h exp=%h", n, last_code, b); end
      end
    end
  endtask

  task automatic test_exclusive();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pulse_excl got=%0d exp=0", both_cnt); end
  endtask

  // --------------------------------------------------------------------------
  // Sequence
  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_frame_errors();
    test_timeout();
    test_selftest();
    test_reset_midframe();
    test_random();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
